// File: rtl/alu_seq_top.sv
// ---------------------------------------------------------------------------
// alu_seq_top
//
// Switch/button driven ALU for the board top level. Operands A and B and the
// opcode all come from the shared switch bank. A rising edge on a button
// (after a two-stage synchroniser) commits exactly one action:
//   i_btn[0] : A      <= i_sw[NB_DATA-1:0]
//   i_btn[1] : B      <= i_sw[NB_DATA-1:0]
//   i_btn[2] : opcode <= i_sw[NB_OP-1:0] and the result of f(A, B, opcode)
//              is registered onto o_led / o_flags / o_op_err
//
// Optional build macro:
//   ALU_ACCUM_EN - a legal evaluation also writes the result back into A,
//                  so that operations can be chained. A coincident load of A
//                  takes priority over the write-back.
//
// Ports:
//   clock     single clock, all logic on the rising edge
//   i_reset   synchronous, active-high reset
//   i_sw      [NB_SW-1:0]   operand / opcode source
//   i_btn     [NB_BTN-1:0]  asynchronous pushbuttons (bit 0 A, 1 B, 2 eval)
//   o_led     [NB_DATA-1:0] registered result
//   o_flags   [3:0]         registered {N, Z, C, V}
//   o_valid                 o_led matches the current A/B registers
//   o_op_err                last evaluated opcode was unsupported
// ---------------------------------------------------------------------------
module alu_seq_top #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_BTN  = 3,
    parameter int NB_SW   = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_DATA-1:0] o_led,
    output logic [3:0]         o_flags,
    output logic               o_valid,
    output logic               o_op_err
);

    localparam int MSB = NB_DATA - 1;

    // Supported opcodes; for NB_OP > 6 the upper bits must be zero.
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    // NB_DATA always fits in NB_DATA bits since NB_DATA < 2**NB_DATA.
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    // Button front end: two-stage synchroniser plus rising-edge detect.
    logic [2:0] btn_s1;
    logic [2:0] btn_s2;
    logic [2:0] pulse;

    logic [NB_DATA-1:0] reg_a;
    logic [NB_DATA-1:0] reg_b;
    logic [NB_OP-1:0]   op_reg;

    logic [NB_OP-1:0]   sw_op;
    logic [NB_DATA:0]   add_ext;
    logic [NB_DATA:0]   sub_ext;
    logic               shift_big;

    logic [NB_DATA-1:0] alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_legal;
    logic [3:0]         alu_flags;

    assign pulse     = btn_s1 & ~btn_s2;
    assign sw_op     = i_sw[NB_OP-1:0];

    // Extra bit carries the carry out (add) or the borrow (sub).
    assign add_ext   = {1'b0, reg_a} + {1'b0, reg_b};
    assign sub_ext   = {1'b0, reg_a} - {1'b0, reg_b};
    assign shift_big = (reg_b >= SHIFT_LIMIT);

    // The opcode under evaluation is taken straight from the switches, so the
    // result is ready in the same cycle as the evaluate pulse.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (sw_op)
            OP_ADD: begin
                alu_res = add_ext[MSB:0];
                alu_c   = add_ext[NB_DATA];
                alu_v   = (reg_a[MSB] == reg_b[MSB]) && (add_ext[MSB] != reg_a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_ext[MSB:0];
                alu_c   = sub_ext[NB_DATA];
                alu_v   = (reg_a[MSB] != reg_b[MSB]) && (sub_ext[MSB] != reg_a[MSB]);
            end
            OP_AND:  alu_res = reg_a & reg_b;
            OP_OR:   alu_res = reg_a | reg_b;
            OP_XOR:  alu_res = reg_a ^ reg_b;
            OP_NOR:  alu_res = ~(reg_a | reg_b);
            OP_SRA:  alu_res = shift_big ? {NB_DATA{reg_a[MSB]}}
                                         : NB_DATA'($signed(reg_a) >>> reg_b);
            OP_SRL:  alu_res = shift_big ? '0 : (reg_a >> reg_b);
            default: alu_legal = 1'b0;
        endcase
    end

    // Illegal opcodes report all-zero flags (alu_res is already zero).
    assign alu_flags = alu_legal ? {alu_res[MSB], (alu_res == '0), alu_c, alu_v} : 4'b0000;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            btn_s1   <= '0;
            btn_s2   <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            op_reg   <= '0;
            o_led    <= '0;
            o_flags  <= '0;
            o_valid  <= 1'b0;
            o_op_err <= 1'b0;
        end else begin
            btn_s1 <= i_btn[2:0];
            btn_s2 <= btn_s1;

            if (pulse[0]) begin
                reg_a <= i_sw[NB_DATA-1:0];
            end
`ifdef ALU_ACCUM_EN
            else if (pulse[2] && alu_legal) begin
                reg_a <= alu_res;
            end
`endif

            if (pulse[1]) begin
                reg_b <= i_sw[NB_DATA-1:0];
            end

            if (pulse[2]) begin
                op_reg   <= sw_op;
                o_led    <= alu_res;
                o_flags  <= alu_flags;
                o_op_err <= ~alu_legal;
                // A coincident operand load makes the fresh result stale.
                o_valid  <= alu_legal & ~pulse[0] & ~pulse[1];
            end else if (pulse[0] || pulse[1]) begin
                o_valid  <= 1'b0;
            end
        end
    end

    // op_reg is kept for debug visibility only; extra switch/button bits beyond
    // the configured widths are intentionally ignored.
    logic unused_sink;
    assign unused_sink = ^{op_reg, i_sw, i_btn};

endmodule

// File: tb/tb_alu_seq_top.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_top
//
// Bench for alu_seq_top (NB_DATA=8, NB_OP=6, NB_BTN=3, NB_SW=8). A reference
// model built from plain integer arithmetic tracks A, B and the outputs from
// the history of button samples; a compare process checks every cycle, and
// directed sequences pin hand-computed values. Define ALU_ACCUM_EN for both
// the bench and the RTL to exercise the accumulate build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_top;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int NB_BTN  = 3;
    localparam int NB_SW   = 8;
    localparam int MODV    = 1 << NB_DATA;
    localparam int HALF    = MODV / 2;

`ifdef ALU_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic               clock;
    logic               i_reset;
    logic [NB_SW-1:0]   i_sw;
    logic [NB_BTN-1:0]  i_btn;
    logic [NB_DATA-1:0] o_led;
    logic [3:0]         o_flags;
    logic               o_valid;
    logic               o_op_err;

    alu_seq_top #(
        .NB_DATA(NB_DATA),
        .NB_OP  (NB_OP),
        .NB_BTN (NB_BTN),
        .NB_SW  (NB_SW)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .i_btn   (i_btn),
        .o_led   (o_led),
        .o_flags (o_flags),
        .o_valid (o_valid),
        .o_op_err(o_op_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state
    int         m_a, m_b, m_led;
    logic [3:0] m_flags;
    bit         m_valid, m_err;
    logic [2:0] samp_now, samp_prev;   // button levels seen at the last two edges

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Behavioural ALU from the arithmetic rules, using signed/unsigned ints.
    task automatic model_alu(input int a, input int b, input int op,
                             output int res, output logic [3:0] fl, output bit legal);
        int sa, sb, s;
        bit c, v;
        sa = (a >= HALF) ? a - MODV : a;
        sb = (b >= HALF) ? b - MODV : b;
        c = 0; v = 0; legal = 1; res = 0;
        case (op)
            32: begin s = a + b; res = s % MODV; c = (s >= MODV);
                      v = ((sa + sb) >= HALF) || ((sa + sb) < -HALF); end
            34: begin res = (a - b + MODV) % MODV; c = (a < b);
                      v = ((sa - sb) >= HALF) || ((sa - sb) < -HALF); end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = (~(a | b)) & (MODV - 1);
            3:  res = (b >= NB_DATA) ? ((sa < 0) ? MODV - 1 : 0) : ((sa >>> b) & (MODV - 1));
            2:  res = (b >= NB_DATA) ? 0 : (a >> b);
            default: legal = 0;
        endcase
        if (legal) fl = {res >= HALF, res == 0, c, v};
        else       fl = 4'b0000;
    endtask

    task automatic model_step();
        logic [2:0] rise;
        int res, sw, op;
        logic [3:0] fl;
        bit legal;
        int new_a;
        if (i_reset) begin
            m_a = 0; m_b = 0; m_led = 0; m_flags = 0; m_valid = 0; m_err = 0;
            samp_now = 0; samp_prev = 0;
        end else begin
            rise  = samp_now & ~samp_prev;
            sw    = int'(i_sw) % MODV;
            op    = int'(i_sw) % (1 << NB_OP);
            new_a = m_a;
            if (rise[2]) begin
                model_alu(m_a, m_b, op, res, fl, legal);
                m_led   = res;
                m_flags = fl;
                m_err   = !legal;
                m_valid = legal && !rise[0] && !rise[1];
                if (ACCUM && legal) new_a = res;
            end else if (rise[0] || rise[1]) begin
                m_valid = 0;
            end
            if (rise[0]) new_a = sw;
            if (rise[1]) m_b = sw;
            m_a = new_a;
            samp_prev = samp_now;
            samp_now  = i_btn[2:0];
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Continuous comparison away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("cyc_led",   32'(o_led),    32'(m_led));
                check("cyc_flags", 32'(o_flags),  32'(m_flags));
                check("cyc_valid", 32'(o_valid),  32'(m_valid));
                check("cyc_err",   32'(o_op_err), 32'(m_err));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            i_btn = '0;
        end
    endtask

    // One clean press: sampled at the next edge, committed at the one after.
    task automatic press(input logic [2:0] mask, input logic [7:0] sw);
        @(negedge clock); i_sw = sw; i_btn = mask;
        @(negedge clock); i_btn = '0;
        @(negedge clock);
    endtask

    task automatic alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        press(3'b001, a);
        press(3'b010, b);
        press(3'b100, op);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] led, input logic [3:0] fl,
                              input logic valid, input logic err);
        check({tag, "_led"},   32'(o_led),    32'(led));
        check({tag, "_flags"}, 32'(o_flags),  32'(fl));
        check({tag, "_valid"}, 32'(o_valid),  32'(valid));
        check({tag, "_err"},   32'(o_op_err), 32'(err));
    endtask

    int ops_tbl[8];

    initial begin
        ops_tbl = '{32, 34, 36, 37, 38, 39, 3, 2};
        i_reset = 1'b1; i_btn = '0; i_sw = '0;
        repeat (2) @(negedge clock);
        expect_out("reset", 8'h00, 4'b0000, 1'b0, 1'b0);
        chk_en = 1'b1;
        i_reset = 1'b0;
        idle(2);

        // 1: ADD overflow plus commit latency
        press(3'b001, 8'h7F);
        press(3'b010, 8'h01);
        @(negedge clock); i_sw = 8'h20; i_btn = 3'b100;
        @(negedge clock); i_btn = '0;
        check("t1_led_not_yet", 32'(o_led), 32'h00);
        @(negedge clock);
        expect_out("t1_add", 8'h80, 4'b1001, 1'b1, 1'b0);

        // 2: SUB borrow, stale after reload, then zero
        alu(8'h05, 8'h07, 8'h22);
        expect_out("t2_sub", 8'hFE, 4'b1010, 1'b1, 1'b0);
        press(3'b010, 8'h05);
        expect_out("t2_reload", 8'hFE, 4'b1010, 1'b0, 1'b0);
        press(3'b001, 8'h05);
        press(3'b100, 8'h22);
        expect_out("t2_zero", 8'h00, 4'b0100, 1'b1, 1'b0);

        // 3: shifts, including amounts past the width
        alu(8'h80, 8'h02, 8'h03);
        expect_out("t3_sra", 8'hE0, 4'b1000, 1'b1, 1'b0);
        alu(8'h80, 8'h09, 8'h02);
        expect_out("t3_srl_big", 8'h00, 4'b0100, 1'b1, 1'b0);
        alu(8'h80, 8'h09, 8'h03);
        expect_out("t3_sra_big", 8'hFF, 4'b1000, 1'b1, 1'b0);

        // 4: illegal opcode, then a legal one clears the error
        alu(8'h0F, 8'h3C, 8'h3F);
        expect_out("t4_illegal", 8'h00, 4'b0000, 1'b0, 1'b1);
        press(3'b100, 8'h24);
        expect_out("t4_and", 8'h0C, 4'b0000, 1'b1, 1'b0);

        // 5: held button acts once, simultaneous pulses, mid-sequence reset
        @(negedge clock); i_sw = 8'h11; i_btn = 3'b001;
        repeat (2) @(negedge clock);
        i_sw = 8'h22;
        repeat (8) @(negedge clock);
        i_btn = '0;
        @(negedge clock);
        press(3'b010, 8'h00);
        press(3'b100, 8'h25);
        expect_out("t5_held", 8'h11, 4'b0000, 1'b1, 1'b0);
        press(3'b110, 8'h20);
        expect_out("t5_simul", 8'h11, 4'b0000, 1'b0, 1'b0);
        press(3'b100, 8'h20);
        expect_out("t5_newb", 8'h31, 4'b0000, 1'b1, 1'b0);
        @(negedge clock); i_sw = 8'h20; i_btn = 3'b100;
        @(negedge clock); i_btn = '0; i_reset = 1'b1;
        @(negedge clock);
        expect_out("t5_reset", 8'h00, 4'b0000, 1'b0, 1'b0);
        i_sw = 8'h44; i_btn = 3'b001;
        repeat (2) @(negedge clock);
        i_reset = 1'b0;
        repeat (4) @(negedge clock);
        i_btn = '0;
        @(negedge clock);
        press(3'b100, 8'h25);
        expect_out("t5_thru_reset", 8'h44, 4'b0000, 1'b1, 1'b0);

        // 6: chained ADD (accumulate build) or repeated ADD
        alu(8'h03, 8'h04, 8'h20);
        expect_out("t6_add1", 8'h07, 4'b0000, 1'b1, 1'b0);
        press(3'b100, 8'h20);
        expect_out("t6_add2", ACCUM ? 8'h0B : 8'h07, 4'b0000, 1'b1, 1'b0);

        // Randomised traffic, checked every cycle against the model
        for (int it = 0; it < 300; it++) begin
            int kind;
            logic [7:0] sw;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       sw = 8'(ops_tbl[$urandom_range(0, 7)] + 64 * $urandom_range(0, 3));
                1:       sw = 8'($urandom_range(0, 11));
                default: sw = 8'($urandom_range(0, 255));
            endcase
            @(negedge clock);
            i_sw  = sw;
            i_btn = 3'($urandom_range(0, 7));
            i_reset = ($urandom_range(0, 99) < 3);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            i_reset = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clock);
                i_btn = '0;
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
